// File: rtl/mips_muldiv.sv
// -----------------------------------------------------------------------------
// mips_muldiv
//
// Iterative multiply/divide unit for the MIPS32 pipeline. It executes
// MULT, MULTU, DIV and DIVU one bit per cycle, using shift-add for multiply
// and restoring division for divide. The double-width result is held in
// HI/LO until the next operation completes.
//
// An accepted operation is visible on done/hi/lo WIDTH+2 edges after the
// edge that accepted it. While the unit is busy, start is ignored and not
// queued. Changes on a/b while busy also have no effect.
//
// Ports
//   clk1         rising-edge clock
//   reset        asynchronous, active-high; clears all state and aborts work
//   start        operation request; sampled only while idle
//   op[1:0]      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a[W-1:0]     multiplicand / dividend, captured on acceptance
//   b[W-1:0]     multiplier / divisor, captured on acceptance
//   busy         high from the cycle after acceptance until done
//   done         one-cycle pulse; hi/lo/div_by_zero valid from that cycle
//   hi[W-1:0]    product upper half, or remainder
//   lo[W-1:0]    product lower half, or quotient
//   div_by_zero  set with done for a divide with b == 0; cleared on next start
// -----------------------------------------------------------------------------
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Operation captured at acceptance
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  // Iteration state
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;       // multiply: {partial, multiplier}; divide: {rem, quo}
  logic [CW-1:0]      cnt;
  logic               res_neg;   // negate product / quotient in FIX
  logic               rem_neg;   // negate remainder in FIX
  logic               dbz;       // divide by zero detected in PREP

  logic is_div;
  logic is_signed;

  assign is_div    = op_r[1];
  assign is_signed = ~op_r[0];

  // ---------------------------------------------------------------------------
  // Operand conditioning (used in PREP)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // The most negative value maps to itself. As an unsigned number that is
  // exactly its magnitude, so MIN needs no special handling here.
  assign a_mag = (is_signed && a_r[WIDTH-1]) ? -a_r : a_r;
  assign b_mag = (is_signed && b_r[WIDTH-1]) ? -b_r : b_r;

  // ---------------------------------------------------------------------------
  // One iteration step (used in RUN)
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  // Multiply: conditionally add the multiplicand into the upper half, with
  // the carry kept in bit WIDTH. Then shift the whole accumulator right by
  // one, so the carry lands in the accumulator MSB.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: the shifted partial remainder needs WIDTH+1 bits. The remainder
  // before the shift is less than the divisor, so after a successful
  // subtract the result fits back into WIDTH bits.
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_rem   = WIDTH'(div_shift - {1'b0, opnd});
  assign div_next  = div_ge ? {div_rem, acc[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  // ---------------------------------------------------------------------------
  // Sign correction (used in FIX)
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = res_neg ? -acc : acc;
  assign quo_fix  = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every flop samples
  // pre-edge values and the ordering of statements cannot create races.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = PREP;
      PREP: state_nxt = RUN;
      RUN:  if (cnt == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      op_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      opnd        <= '0;
      acc         <= '0;
      cnt         <= '0;
      res_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      dbz         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_r        <= op;
            a_r         <= a;
            b_r         <= b;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
          end
        end
        PREP: begin
          // Multiply keeps the multiplier in the low half and consumes it LSB
          // first. Divide shifts the dividend out of the low half into the
          // remainder. In both cases the upper half starts cleared.
          opnd    <= is_div ? b_mag : a_mag;
          acc     <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
          cnt     <= CW'(WIDTH);
          res_neg <= is_signed & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          rem_neg <= is_signed & a_r[WIDTH-1];
          dbz     <= is_div & (b_r == '0);
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          if (!is_div) begin
            {hi, lo} <= prod_fix;
          end else if (dbz) begin
            // Fixed divide-by-zero result: dividend passed through as-is.
            hi <= a_r;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          div_by_zero <= dbz;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// -----------------------------------------------------------------------------
// tb_mips_muldiv
//
// Self-checking bench for mips_muldiv at WIDTH = 32. Expected results come
// from a plain-arithmetic reference model: 64-bit products and SystemVerilog
// integer / and %, which truncate toward zero. Directed cases are followed
// by randomized operations.
// -----------------------------------------------------------------------------
module tb_mips_muldiv;

  localparam int W       = 32;
  localparam int LATENCY = W + 2;

  logic         clk1 = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  mips_muldiv #(.WIDTH(W)) dut (
    .clk1        (clk1),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Reference model, computed directly from the arithmetic rules.
  function automatic void model(input logic [1:0] m_op, input logic [31:0] m_a, input logic [31:0] m_b,
                                output logic [31:0] m_hi, output logic [31:0] m_lo, output logic m_dbz);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    int          ia;
    int          ib;
    m_dbz = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
    case (m_op)
      2'b00: begin
        sa = longint'($signed(m_a));
        sb = longint'($signed(m_b));
        p  = 64'(sa * sb);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      2'b01: begin
        p = {32'b0, m_a} * {32'b0, m_b};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      default: begin
        if (m_b == 0) begin
          m_dbz = 1'b1;
          m_hi  = m_a;
          m_lo  = 32'hFFFF_FFFF;
        end else if (m_op == 2'b11) begin
          m_lo = m_a / m_b;
          m_hi = m_a % m_b;
        end else if (m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'h0;
        end else begin
          ia = m_a;
          ib = m_b;
          m_lo = 32'(ia / ib);
          m_hi = 32'(ia % ib);
        end
      end
    endcase
  endfunction

  // Wait for done with a cycle budget. Call at #1 after the accepting edge;
  // returns #1 after the edge that raised done, or after the budget runs out.
  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 100) begin
      @(posedge clk1);
      #1;
      cycles++;
    end
    check({tag, " done seen"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(cycles), 32'(LATENCY));
  endtask

  // Issue one operation and check timing and result against the model.
  // If inject_at > 0, a spurious DIV start with new a/b is pulsed that many
  // cycles into the operation.
  task automatic run_op(input string tag, input logic [1:0] t_op, input logic [31:0] t_a,
                        input logic [31:0] t_b, input int inject_at);
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_dbz;
    int          cycles;
    model(t_op, t_a, t_b, e_hi, e_lo, e_dbz);
    @(negedge clk1);
    start = 1'b1;
    op    = t_op;
    a     = t_a;
    b     = t_b;
    @(posedge clk1);
    #1;
    start = 1'b0;
    check({tag, " busy after accept"}, 32'(busy), 32'd1);
    check({tag, " dbz cleared"}, 32'(div_by_zero), 32'd0);
    cycles = 0;
    while (done !== 1'b1 && cycles < 100) begin
      @(posedge clk1);
      #1;
      cycles++;
      if (inject_at > 0 && cycles == inject_at) begin
        start = 1'b1;
        op    = 2'b10;
        a     = $urandom;
        b     = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, " done seen"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(cycles), 32'(LATENCY));
    check({tag, " hi"}, hi, e_hi);
    check({tag, " lo"}, lo, e_lo);
    check({tag, " dbz"}, 32'(div_by_zero), 32'(e_dbz));
    check({tag, " busy low"}, 32'(busy), 32'd0);
    @(posedge clk1);
    #1;
    check({tag, " done one cycle"}, 32'(done), 32'd0);
  endtask

  initial begin : stim
    int          cycles;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk1);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk1);
    reset = 1'b0;

    // Directed cases
    run_op("mult 30*10",      2'b00, 32'd30,         32'd10,         0);
    run_op("mult -3*7",       2'b00, 32'hFFFF_FFFD,  32'd7,          0);
    run_op("multu max*max",   2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0);
    run_op("mult min*min",    2'b00, 32'h8000_0000,  32'h8000_0000,  0);
    run_op("div -7/2",        2'b10, 32'hFFFF_FFF9,  32'd2,          0);
    run_op("div 7/-2",        2'b10, 32'd7,          32'hFFFF_FFFE,  0);
    run_op("divu 30/10",      2'b11, 32'd30,         32'd10,         0);
    run_op("div min/-1",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  0);
    run_op("divu 30/0",       2'b11, 32'd30,         32'd0,          0);
    run_op("div -5/0",        2'b10, 32'hFFFF_FFFB,  32'd0,          0);
    run_op("divu max/1",      2'b11, 32'hFFFF_FFFF,  32'd1,          0);
    run_op("divu after dbz",  2'b11, 32'd100,        32'd7,          0);
    run_op("start ignored",   2'b11, 32'd12345,      32'd67,         10);

    // Back-to-back: start held high through done is accepted on the next edge
    @(negedge clk1);
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd5;
    b     = 32'd6;
    @(posedge clk1);
    #1;
    check("b2b first accept", 32'(busy), 32'd1);
    a = 32'd7;
    b = 32'd8;
    wait_done("b2b first", cycles);
    check("b2b first lo", lo, 32'd30);
    @(posedge clk1);
    #1;
    start = 1'b0;
    check("b2b second accept", 32'(busy), 32'd1);
    check("b2b done dropped", 32'(done), 32'd0);
    wait_done("b2b second", cycles);
    check("b2b second lo", lo, 32'd56);
    check("b2b second hi", hi, 32'd0);

    // Reset mid-operation aborts immediately with no done pulse
    @(negedge clk1);
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd1000;
    b     = 32'd2000;
    @(posedge clk1);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk1);
    @(negedge clk1);
    reset = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    repeat (3) begin
      @(posedge clk1);
      #1;
      check("abort no done", 32'(done), 32'd0);
    end
    @(negedge clk1);
    reset = 1'b0;
    run_op("mult after abort", 2'b00, 32'd30, 32'd10, 0);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       r_a = 32'h8000_0000;
        1:       r_a = 32'($urandom_range(0, 255));
        default: r_a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 15));
        2:       r_b = 32'hFFFF_FFFF;
        default: r_b = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
